// File: rtl/align_add.sv
//------------------------------------------------------------------------------
// Module      : align_add
// Description : Floating-point adder front end. Aligns the smaller-exponent
//               mantissa with a one-bit-per-cycle shifter, then adds/subtracts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module align_add #(
    parameter int EW = 8,
    parameter int MW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [EW+MW-1:0]  a,
    input  logic [EW+MW-1:0]  b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MW:0]       mxy1,
    output logic [EW-1:0]     ex,
    output logic              s,
    output logic              s1,
    output logic              s2,
    output logic              s3,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int            c_CW   = $clog2(MW + 1);
    localparam logic [EW-1:0] c_MW_E = EW'(MW);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_ADD   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [MW-1:0]   r_l;
    logic [MW-1:0]   r_sm;
    logic [EW-1:0]   r_el;
    logic [c_CW-1:0] r_cnt;
    logic [MW:0]     r_mxy1;
    logic [EW-1:0]   r_ex;
    logic            r_s;
    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic            r_out_valid;

    logic [EW-1:0]   w_ea;
    logic [EW-1:0]   w_eb;
    logic [MW-1:0]   w_ma;
    logic [MW-1:0]   w_mb;
    logic            w_a_ge;
    logic [EW-1:0]   w_d;
    logic            w_sat;
    logic [c_CW-1:0] w_cnt;

    // Hidden bit is implied only for non-zero exponents (denormals/zero get 0).
    assign w_ea   = a[EW+MW-2 -: EW];
    assign w_eb   = b[EW+MW-2 -: EW];
    assign w_ma   = {(|w_ea), a[MW-2:0]};
    assign w_mb   = {(|w_eb), b[MW-2:0]};
    assign w_a_ge = (w_ea >= w_eb);
    assign w_d    = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_sat  = (w_d > c_MW_E);
    assign w_cnt  = w_sat ? '0 : w_d[c_CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_l         <= '0;
            r_sm        <= '0;
            r_el        <= '0;
            r_cnt       <= '0;
            r_mxy1      <= '0;
            r_ex        <= '0;
            r_s         <= 1'b0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_s1  <= a[EW+MW-1];
                        r_s2  <= b[EW+MW-1];
                        r_s3  <= a[EW+MW-1] ^ b[EW+MW-1];
                        r_s   <= w_a_ge;
                        r_l   <= w_a_ge ? w_ma : w_mb;
                        r_sm  <= w_sat ? '0 : (w_a_ge ? w_mb : w_ma);
                        r_el  <= w_a_ge ? w_ea : w_eb;
                        r_cnt <= w_cnt;
                        r_state <= (w_cnt != '0) ? c_SHIFT : c_ADD;
                    end
                end
                c_SHIFT: begin
                    // Truncating shift: bits falling off the LSB are lost.
                    r_sm  <= r_sm >> 1;
                    r_cnt <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) begin
                        r_state <= c_ADD;
                    end
                end
                c_ADD: begin
                    r_mxy1 <= r_s3 ? ({1'b0, r_l} - {1'b0, r_sm})
                                   : ({1'b0, r_l} + {1'b0, r_sm});
                    r_ex        <= r_el + EW'(1);
                    r_out_valid <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign mxy1      = r_mxy1;
    assign ex        = r_ex;
    assign s         = r_s;
    assign s1        = r_s1;
    assign s2        = r_s2;
    assign s3        = r_s3;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_align_add.sv
//------------------------------------------------------------------------------
// Module      : tb_align_add
// Description : Directed, table-driven bench for align_add.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_align_add;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] mxy1;
    logic [7:0]  ex;
    logic        s;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [24:0] mxy1;
        logic [7:0]  ex;
        logic        s;
        logic        s1;
        logic        s2;
        logic        s3;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    align_add #(.EW(8), .MW(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mxy1      (mxy1),
        .ex        (ex),
        .s         (s),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for its result and compare every field.
    task automatic run_op(input vec_t v);
        int cyc;
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        check({v.name, " latency"},   32'(cyc),       32'(v.lat));
        check({v.name, " mxy1"},      32'(mxy1),      32'(v.mxy1));
        check({v.name, " ex"},        32'(ex),        32'(v.ex));
        check({v.name, " sflags"},    32'({s, s1, s2, s3}), 32'({v.s, v.s1, v.s2, v.s3}));
    endtask

    task automatic release_op(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " drain out_valid"}, 32'(out_valid), 32'd0);
        check({name, " drain in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        //        name        a             b             mxy1          ex     s     s1    s2    s3    lat
        vecs[0] = '{"eq",     32'h3F800000, 32'h3F800000, 25'h1000000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1] = '{"sh1",    32'h3F800000, 32'h3F000000, 25'h0C00000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[2] = '{"sh1swp", 32'h3F000000, 32'h3F800000, 25'h0C00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[3] = '{"negdif", 32'h3F800000, 32'hBFC00000, 25'h1C00000, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        vecs[4] = '{"d24",    32'h4B800000, 32'h3F800000, 25'h0800000, 8'h98, 1'b1, 1'b0, 1'b0, 1'b0, 25};
        vecs[5] = '{"d30sat", 32'h4B800000, 32'h3C800000, 25'h0800000, 8'h98, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[6] = '{"subsh",  32'h40000000, 32'hBF800000, 25'h0400000, 8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        vecs[7] = '{"zeros",  32'h00000000, 32'h00000000, 25'h0000000, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1};

        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        // Operands offered during reset must be dropped.
        tick();
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset mxy1",      32'(mxy1),      32'd0);
        check("reset ex",        32'(ex),        32'd0);
        check("reset sflags",    32'({s, s1, s2, s3}), 32'd0);
        tick();
        check("idle after reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
            release_op(vecs[i].name);
        end

        // Backpressure: result held, new operands ignored.
        run_op(vecs[1]);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 32'h40000000;
                b = 32'hBF800000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready",  32'(in_ready),  32'd0);
            check("bp mxy1",      32'(mxy1),      32'(vecs[1].mxy1));
            check("bp ex",        32'(ex),        32'(vecs[1].ex));
            check("bp sflags",    32'({s, s1, s2, s3}), 32'({vecs[1].s, vecs[1].s1, vecs[1].s2, vecs[1].s3}));
        end
        in_valid = 1'b0;
        release_op("bp");
        tick();
        check("bp no ghost op", 32'(in_ready), 32'd1);

        // Reset in the middle of a long alignment.
        a = vecs[4].a;
        b = vecs[4].b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid in_ready busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst in_ready",  32'(in_ready),  32'd1);
        check("mid rst mxy1",      32'(mxy1),      32'd0);
        check("mid rst ex",        32'(ex),        32'd0);
        check("mid rst sflags",    32'({s, s1, s2, s3}), 32'd0);
        run_op(vecs[0]);
        release_op("after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/align_add.md
Name: align_add

Overview:
- Front end of the floating-point adder in the MAC datapath, sitting directly upstream of the normalise stage.
- Accepts two IEEE-754 single-precision operands and compares their exponents.
- Right-shifts the smaller-exponent mantissa one bit per cycle, then adds or subtracts the aligned mantissas.
- Presents the raw 25-bit two's-complement sum, the pre-incremented exponent and the sign-select flags (mxy1, ex, s, s1, s2, s3) in exactly the form the normalise stage consumes.
- Uses a valid/ready handshake on both sides.

Parameters:
EW, 8, exponent width
MW, 24, mantissa width including hidden bit; sum width is MW+1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
a  input  EW+MW  operand A, IEEE-754 layout {sign, exp, frac}
b  input  EW+MW  operand B, same layout
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
mxy1  output  MW+1  aligned sum or difference, two's complement (bit MW set means carry, or negative when s3=1)
ex  output  EW  larger exponent + 1 (mod 2^EW)
s  output  1  1 when A has the larger-or-equal exponent (A's sign governs the result)
s1  output  1  sign of A
s2  output  1  sign of B
s3  output  1  effective subtract, s1^s2
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset:
  - rst has priority over every other input and is sampled only at the clk edge.
  - On reset: state goes to IDLE; out_valid=0; mxy1=0; ex=0; s, s1, s2, s3 = 0.
  - Operands presented during a reset cycle are dropped.
  - Reset mid-operation discards the in-flight operation.
- Mantissas: hidden bit = 1 if exp != 0, else 0. mA={hA,fracA}, mB={hB,fracB}.
- State machine (IDLE, SHIFT, ADD, DONE); in_ready = (state==IDLE), combinational from state.
- IDLE:
  - On in_valid, capture s1, s2, s3 and s = (eA >= eB); a tie gives s=1.
  - Capture L = mantissa of the selected operand and S = the other mantissa.
  - Capture eL = max(eA,eB) and d = |eA-eB|.
  - If d > MW: S=0, count=0. Otherwise count=d.
  - Next state is SHIFT if count != 0, else ADD.
- SHIFT: each cycle S = S>>1 (zero fill, shifted-out bits discarded: truncation, no guard/sticky) and count decrements. When count reaches 0, go to ADD.
- ADD (one cycle):
  - mxy1 = s3 ? {0,L}-{0,S} : {0,L}+{0,S}, modulo 2^(MW+1).
  - ex = eL+1 (8-bit wrap).
  - Set out_valid=1 and go to DONE.
- DONE:
  - All outputs hold stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next edge, go to IDLE.
  - in_ready=0, and in_valid is ignored.
- Latency:
  - Accept edge k; out_valid rises at edge k+n+1, where n = shift count (0..MW).
  - Minimum 1 cycle, maximum MW+1 cycles.
  - Throughput is one operation per n+3 cycles at best (no overlap).
- Equal-exponent subtract with |L|<|S| gives mxy1[MW]=1 (negative); the downstream stage negates it and flips the sign.
- Exponent 255 (inf/NaN) inputs are unsupported: the result is defined by the arithmetic above, with no special handling.
- mxy1/ex values are undefined-but-stable when out_valid=0; the bench checks them only with out_valid=1.

Test Plan:
- Equal exponents: a=0x3F800000, b=0x3F800000 -> out_valid 1 cycle after accept; mxy1=0x1000000, ex=0x80, s=1, s1=0, s2=0, s3=0.
- One-bit shift, both orders:
  - a=0x3F800000, b=0x3F000000 -> 2-cycle latency; mxy1=0x0C00000, ex=0x80, s=1.
  - Swapped operands -> same mxy1/ex with s=0.
- Negative difference: a=0x3F800000, b=0xBFC00000 -> mxy1=0x1C00000, ex=0x80, s=1, s1=0, s2=1, s3=1.
- Long and saturated shift:
  - a=0x4B800000, b=0x3F800000 (d=24) -> 24 SHIFT cycles, latency 25; mxy1=0x0800000, ex=0x98.
  - b=0x3C800000 (d=30) -> saturate, latency 1; mxy1=0x0800000.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> outputs unchanged, in_ready=0, a new in_valid pulse is ignored.
  - Then out_ready=1 -> out_valid=0 and in_ready=1 on the next edge.
- Reset mid-SHIFT: assert rst for 1 cycle during the d=24 case -> next edge out_valid=0, in_ready=1, outputs 0; a following 1.0+1.0 completes correctly.
